tone_sequencer: RTL and testbench

//  Parametrised square-wave tone engine for the piezo speaker. Accepts one timed note per

---
 rtl/tone_pkg.sv | 67 ++++++
 rtl/tone_sequencer_ms_tick_gen.sv | 39 +++
 rtl/tone_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_tone_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// -----------------------------------------------------------------------------
// tone_pkg
// Shared definitions for the piezo tone sequencer:
//   - note codes (1..7 = do..si, everything else is a rest)
//   - C3..B3 note frequencies in centi-Hz
//   - half_period(): clock cycles per half square-wave period for a note
//   - octave select encodings
//   - sequencer FSM state type
// -----------------------------------------------------------------------------
package tone_pkg;

   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [3:0] NOTE_DO   = 4'd1;
   localparam logic [3:0] NOTE_RE   = 4'd2;
   localparam logic [3:0] NOTE_MI   = 4'd3;
   localparam logic [3:0] NOTE_FA   = 4'd4;
   localparam logic [3:0] NOTE_SOL  = 4'd5;
   localparam logic [3:0] NOTE_LA   = 4'd6;
   localparam logic [3:0] NOTE_SI   = 4'd7;

   // C3..B3 in centi-Hz (hundredths of a hertz)
   localparam longint unsigned FREQ_C3_CHZ = 64'd13081;
   localparam longint unsigned FREQ_D3_CHZ = 64'd14683;
   localparam longint unsigned FREQ_E3_CHZ = 64'd16481;
   localparam longint unsigned FREQ_F3_CHZ = 64'd17461;
   localparam longint unsigned FREQ_G3_CHZ = 64'd19600;
   localparam longint unsigned FREQ_A3_CHZ = 64'd22000;
   localparam longint unsigned FREQ_B3_CHZ = 64'd24694;

   localparam logic [1:0] OCT_BASE     = 2'b00;
   localparam logic [1:0] OCT_LOWER    = 2'b01;
   localparam logic [1:0] OCT_HIGHER   = 2'b10;
   localparam logic [1:0] OCT_BASE_ALT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TONE = 2'd1,
      GAP  = 2'd2
   } state_e;

   // Frequency of a note code in centi-Hz; 0 for rest codes.
   function automatic longint unsigned note_freq_chz(input logic [3:0] code);
      longint unsigned f;
      case (code)
         NOTE_DO:  f = FREQ_C3_CHZ;
         NOTE_RE:  f = FREQ_D3_CHZ;
         NOTE_MI:  f = FREQ_E3_CHZ;
         NOTE_FA:  f = FREQ_F3_CHZ;
         NOTE_SOL: f = FREQ_G3_CHZ;
         NOTE_LA:  f = FREQ_A3_CHZ;
         NOTE_SI:  f = FREQ_B3_CHZ;
         default:  f = 64'd0;
      endcase
      return f;
   endfunction

   // CLK_HZ / (2 * f_note), truncated. The x100 undoes the centi-Hz scaling;
   // 64-bit math keeps 100 MHz * 100 from overflowing. Rests return 0.
   function automatic longint unsigned half_period(input longint unsigned clk_hz,
                                                   input logic [3:0]      code);
      longint unsigned f;
      f = note_freq_chz(code);
      if (f == 64'd0) return 64'd0;
      return (clk_hz * 64'd100) / (64'd2 * f);
   endfunction

endpackage

// File: rtl/tone_sequencer_ms_tick_gen.sv
// -----------------------------------------------------------------------------
// ms_tick_gen
// Millisecond prescaler. tick is high for one cycle every CLK_HZ/1000 cycles;
// restart forces the count back to 0 so the first tick after a restart lands
// exactly CLK_HZ/1000 cycles later.
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   restart  in  resynchronise the prescaler (count <= 0)
//   tick     out one-cycle pulse, last cycle of each millisecond
// -----------------------------------------------------------------------------
module ms_tick_gen #(
   parameter int unsigned CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned     TICKS = CLK_HZ / 1000;
   localparam int unsigned     PRE_W = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [PRE_W-1:0] LAST = PRE_W'(TICKS - 1);

   logic [PRE_W-1:0] pre_q, pre_d;

   always_comb begin
      pre_d = pre_q + PRE_W'(1);
      if (restart || (pre_q == LAST)) pre_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pre_q <= '0;
      else        pre_q <= pre_d;
   end

   assign tick = (pre_q == LAST);

endmodule

// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
// Square-wave tone engine for the piezo speaker. Accepts one timed note per
// valid/ready handshake, plays it for dur_ms milliseconds, then stays silent
// for gap_ms milliseconds before accepting the next one.
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   note_valid, note_ready  request handshake (ready only in IDLE)
//   note, octave        note code and octave shift, sampled on transfer
//   dur_ms, gap_ms      tone and trailing-silence lengths in ms, sampled on transfer
//   mute                live speaker gate; timing is not affected
//   speaker             square-wave drive
//   busy                high while playing or in the trailing gap
//   done                one-cycle pulse on return to IDLE
// -----------------------------------------------------------------------------
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned CNT_W  = 24,
   parameter int unsigned DUR_W  = 16,
   parameter int unsigned NOTE_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              note_valid,
   output logic              note_ready,
   input  logic [NOTE_W-1:0] note,
   input  logic [1:0]        octave,
   input  logic [DUR_W-1:0]  dur_ms,
   input  logic [DUR_W-1:0]  gap_ms,
   input  logic              mute,
   output logic              speaker,
   output logic              busy,
   output logic              done
);

   // Do has the longest half-period, so it bounds the lower-octave shift.
   localparam longint unsigned H_MAX = half_period(64'(CLK_HZ), NOTE_DO);

   if ((H_MAX << 1) >= (64'd1 << CNT_W)) begin : g_cnt_w_check
      $error("CNT_W too narrow for the lower-octave half-period");
   end

   localparam logic [CNT_W-1:0] H_TABLE [8] = '{
      '0,
      CNT_W'(half_period(64'(CLK_HZ), NOTE_DO)),
      CNT_W'(half_period(64'(CLK_HZ), NOTE_RE)),
      CNT_W'(half_period(64'(CLK_HZ), NOTE_MI)),
      CNT_W'(half_period(64'(CLK_HZ), NOTE_FA)),
      CNT_W'(half_period(64'(CLK_HZ), NOTE_SOL)),
      CNT_W'(half_period(64'(CLK_HZ), NOTE_LA)),
      CNT_W'(half_period(64'(CLK_HZ), NOTE_SI))
   };

   state_e             state_q, state_d;
   logic [DUR_W-1:0]   remain_q, remain_d;   // ms left in the current phase
   logic [DUR_W-1:0]   gap_q, gap_d;
   logic [CNT_W-1:0]   half_q, half_d;
   logic               rest_q, rest_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               phase_q, phase_d;     // square-wave phase, before gating
   logic               done_q, done_d;

   logic               tick;
   logic               restart;
   logic               new_rest;
   logic [CNT_W-1:0]   base_h;
   logic [CNT_W-1:0]   new_half;

   ms_tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_ms_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .tick    (tick)
   );

   // Half-period for the offered note, octave shift applied before latching.
   always_comb begin
      new_rest = (note == NOTE_W'(0)) || (note > NOTE_W'(7));
      base_h   = new_rest ? '0 : H_TABLE[note[2:0]];
      case (octave)
         OCT_LOWER:  new_half = base_h << 1;
         OCT_HIGHER: new_half = base_h >> 1;
         default:    new_half = base_h;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      gap_d    = gap_q;
      half_d   = half_q;
      rest_d   = rest_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      done_d   = 1'b0;
      restart  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (note_valid) begin
               restart = 1'b1;
               half_d  = new_half;
               rest_d  = new_rest;
               gap_d   = gap_ms;
               cnt_d   = '0;
               phase_d = 1'b0;
               if (dur_ms != '0) begin
                  state_d  = TONE;
                  remain_d = dur_ms;
               end else if (gap_ms != '0) begin
                  state_d  = GAP;
                  remain_d = gap_ms;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         TONE: begin
            // Wrap at H-1 so each phase lasts exactly H cycles.
            if (cnt_q == half_q - CNT_W'(1)) begin
               cnt_d   = '0;
               phase_d = ~phase_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (tick) begin
               if (remain_q == DUR_W'(1)) begin
                  if (gap_q != '0) begin
                     state_d  = GAP;
                     remain_d = gap_q;
                     restart  = 1'b1;
                  end else begin
                     state_d  = IDLE;
                     remain_d = '0;
                     done_d   = 1'b1;
                  end
               end else begin
                  remain_d = remain_q - DUR_W'(1);
               end
            end
         end

         GAP: begin
            if (tick) begin
               if (remain_q == DUR_W'(1)) begin
                  state_d  = IDLE;
                  remain_d = '0;
                  done_d   = 1'b1;
               end else begin
                  remain_d = remain_q - DUR_W'(1);
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         remain_q <= '0;
         gap_q    <= '0;
         half_q   <= '0;
         rest_q   <= 1'b0;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         gap_q    <= gap_d;
         half_q   <= half_d;
         rest_q   <= rest_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         done_q   <= done_d;
      end
   end

   assign note_ready = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   // Gated outside the phase register so mute never disturbs the waveform timing.
   assign speaker    = (state_q == TONE) && !rest_q && !mute && phase_q;

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

   localparam int unsigned CLK_HZ = 100_000;
   localparam int          CPM    = CLK_HZ / 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        note_valid = 1'b0;
   logic        note_ready;
   logic [3:0]  note = '0;
   logic [1:0]  octave = '0;
   logic [15:0] dur_ms = '0;
   logic [15:0] gap_ms = '0;
   logic        mute = 1'b0;
   logic        speaker;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   tone_sequencer #(
      .CLK_HZ (CLK_HZ),
      .CNT_W  (24),
      .DUR_W  (16),
      .NOTE_W (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .note       (note),
      .octave     (octave),
      .dur_ms     (dur_ms),
      .gap_ms     (gap_ms),
      .mute       (mute),
      .speaker    (speaker),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      int nt;
      int oc;
      int du;
      int ga;
   } req_t;

   req_t q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: the note being played, described by its start cycle
   // and lengths; every output is derived arithmetically from those.
   bit m_have = 1'b0;
   int m_p, m_d, m_g, m_h;
   bit m_rest;
   bit mute_rand = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic int half_of(input int nt, input int oc);
      int chz;
      int base;
      case (nt)
         1: chz = 13081;
         2: chz = 14683;
         3: chz = 16481;
         4: chz = 17461;
         5: chz = 19600;
         6: chz = 22000;
         7: chz = 24694;
         default: chz = 0;
      endcase
      if (chz == 0) return 0;
      base = (int'(CLK_HZ) * 100) / (2 * chz);
      if (oc == 1) return base * 2;
      if (oc == 2) return base / 2;
      return base;
   endfunction

   function automatic bit model_idle();
      if (!m_have) return 1'b1;
      return (cyc - m_p) >= CPM * (m_d + m_g);
   endfunction

   task automatic drive_next();
      req_t r;
      if (mute_rand && ($urandom_range(0, 99) == 0)) mute = !mute;
      if (!rst_n) begin
         note_valid = 1'b0;
      end else if (model_idle() && q.size() > 0) begin
         r          = q.pop_front();
         note_valid = 1'b1;
         note       = 4'(r.nt);
         octave     = 2'(r.oc);
         dur_ms     = 16'(r.du);
         gap_ms     = 16'(r.ga);
         m_have     = 1'b1;
         m_p        = cyc + 1;
         m_d        = r.du;
         m_g        = r.ga;
         m_rest     = (r.nt == 0) || (r.nt > 7);
         m_h        = half_of(r.nt, r.oc);
      end else if (!model_idle()) begin
         // Busy: the DUT must ignore whatever is offered.
         note_valid = 1'($urandom_range(0, 1));
         note       = 4'($urandom_range(0, 15));
         octave     = 2'($urandom_range(0, 3));
         dur_ms     = 16'($urandom_range(0, 65535));
         gap_ms     = 16'($urandom_range(0, 65535));
      end else begin
         note_valid = 1'b0;
      end
   endtask

   task automatic step();
      int rel;
      int len;
      bit e_busy;
      bit e_done;
      bit e_spk;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      e_busy = 1'b0;
      e_done = 1'b0;
      e_spk  = 1'b0;
      if (m_have) begin
         rel    = cyc - m_p;
         len    = CPM * (m_d + m_g);
         e_busy = (rel < len);
         e_done = (rel == len);
         if (!m_rest && !mute && rel < CPM * m_d) e_spk = ((rel / m_h) % 2) == 1;
      end
      chk("busy",    int'(busy),       int'(e_busy));
      chk("ready",   int'(note_ready), int'(!e_busy));
      chk("done",    int'(done),       int'(e_done));
      chk("speaker", int'(speaker),    int'(e_spk));
      drive_next();
   endtask

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      while (!(q.size() == 0 && model_idle())) begin
         if (n >= budget) begin
            chk("timeout", n, 0);
            return;
         end
         step();
         n++;
      end
   endtask

   task automatic push(input int nt, input int oc, input int du, input int ga);
      req_t r;
      r.nt = nt;
      r.oc = oc;
      r.du = du;
      r.ga = ga;
      q.push_back(r);
   endtask

   initial begin
      // Power-on reset
      #1;
      chk("rst_busy",  int'(busy),       0);
      chk("rst_spk",   int'(speaker),    0);
      chk("rst_done",  int'(done),       0);
      chk("rst_ready", int'(note_ready), 1);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (3) step();

      // Directed notes, queued together so each follows in the previous done cycle
      push(1, 0, 3, 1);    // H=382, period 764, done at +400
      push(1, 1, 16, 0);   // H=764
      push(1, 2, 4, 1);    // H=191
      push(0, 0, 2, 1);    // rest code 0
      push(9, 0, 2, 1);    // rest code 9
      push(1, 0, 0, 0);    // done next cycle, no tone
      push(1, 0, 0, 2);    // 200 silent cycles
      run_until_idle(10000);
      repeat (2) step();

      // Mute toggled mid-tone
      push(3, 0, 5, 0);
      step();
      repeat (100) step();
      mute = 1'b1;
      repeat (150) step();
      mute = 1'b0;
      run_until_idle(2000);
      repeat (2) step();

      // Reset in the middle of a tone: abort at once, no done afterwards
      push(2, 0, 3, 1);
      step();
      repeat (150) step();
      rst_n      = 1'b0;
      note_valid = 1'b0;
      m_have     = 1'b0;
      #1;
      chk("abort_busy",  int'(busy),       0);
      chk("abort_spk",   int'(speaker),    0);
      chk("abort_done",  int'(done),       0);
      chk("abort_ready", int'(note_ready), 1);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (10) step();

      // Randomised notes, single or back-to-back pairs, with random mute
      mute_rand = 1'b1;
      repeat (40) begin
         push($urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2));
         if ($urandom_range(0, 2) == 0)
            push($urandom_range(0, 15), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
         run_until_idle(3000);
         repeat ($urandom_range(0, 4)) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
